usb_data_buffer: RTL and testbench
==================================

# usb_data_buffer

Single 64-byte FIFO shared by the AHB-side interface and the USB packet engines of the endpoint. It sits directly upstream of the USB transmitter: it accepts bytes from the host-bus side and supplies them to the transmitter one byte per `get_tx_packet_data` strobe. It also accepts bytes from the USB receiver for host-bus reads. It reports live occupancy so the transmitter can size packets and the bus side can flag data availability.

## Interface
- `DEPTH`, 64, number of byte entries. Must be a power of two, at least 2. Pointer width is log2(DEPTH); occupancy width is log2(DEPTH)+1.
- `clk` input 1: system clock, all state on the rising edge.
- `n_rst` input 1: asynchronous active-low reset.
- `flush` input 1: bus-side synchronous empty request.
- `clear` input 1: receiver-side synchronous empty request, asserted at start of an incoming data packet.
- `store_tx_data` input 1: bus-side push strobe.
- `tx_data` input 8: byte pushed with `store_tx_data`.
- `store_rx_packet_data` input 1: receiver push strobe.
- `rx_packet_data` input 8: byte pushed with `store_rx_packet_data`.
- `get_tx_packet_data` input 1: transmitter pop strobe.
- `get_rx_data` input 1: bus-side pop strobe.
- `tx_packet_data` output 8: head byte presented to the transmitter.
- `rx_data` output 8: head byte presented to the bus side.
- `buffer_occupancy` output 7: number of valid bytes, range 0..64.

## Operation
- Storage:
  - DEPTH x 8 register array, all entries reset to 8'h00.
  - 6-bit write pointer `wptr` and read pointer `rptr`, both reset to 0.
  - 7-bit occupancy counter, reset to 0.
- Push:
  - push = `store_tx_data` | `store_rx_packet_data`.
  - If both strobes are high, `rx_packet_data` is stored and `tx_data` is dropped.
  - The byte is written to entry `wptr`; `wptr` increments modulo DEPTH (63 -> 0).
- Pop:
  - pop = `get_tx_packet_data` | `get_rx_data`.
  - Both strobes high counts as one pop.
  - `rptr` increments modulo DEPTH.
- Head presentation:
  - First-word-fall-through, combinational from the array and `rptr`.
  - `tx_packet_data` = `rx_data` = mem[`rptr`] when occupancy > 0; 8'h00 when occupancy = 0.
- Occupancy update per cycle (after flush/clear check):
  - push accepted only, +1.
  - pop accepted only, -1.
  - both accepted, unchanged.
- Boundary rules:
  - Empty, pop only: ignored. Pointers and occupancy unchanged; no underflow.
  - Full (64), push only: ignored. Array, `wptr` and occupancy unchanged; no overflow.
  - Empty, push+pop same cycle: push accepted, pop ignored, occupancy becomes 1.
  - Full, push+pop same cycle: both accepted, occupancy stays 64. The written byte lands in the slot vacated by the pop.
  - `flush` or `clear` high: `wptr`, `rptr` and occupancy go to 0 at the next edge. This overrides any push or pop in the same cycle. Array contents are not cleared.
- Reset mid-operation: asynchronous return to all reset values; any in-flight packet data is lost.

## Timing
- Push visible at the next rising edge:
  - occupancy reflects it the cycle after the strobe;
  - a byte pushed into an empty buffer appears on `tx_packet_data` one cycle after the strobe.
- Pop: the head byte is valid in the same cycle as `get_tx_packet_data`. The next byte is presented the cycle after the strobe. The transmitter may pop on consecutive cycles.
- `buffer_occupancy` is registered; it changes only on a clock edge or on reset.
- Data outputs are combinational from registers; no input-to-output combinational path.
- Reset values: `tx_packet_data` = 8'h00, `rx_data` = 8'h00, `buffer_occupancy` = 0.

## Test plan
- Reset, then push 8'hA5, 8'h3C with `store_tx_data` -> occupancy 2, `tx_packet_data` = 8'hA5. Pop once -> 8'h3C, occupancy 1.
- Push 64 bytes 8'h00..8'h3F -> occupancy 64. Push 8'hFF -> ignored, occupancy 64. Pop 64 times -> data 8'h00..8'h3F in order, occupancy 0. Further pop -> occupancy 0, output 8'h00.
- Wrap-around:
  - Push 60 and pop 60 bytes, then push 10 bytes 8'h10..8'h19 (`wptr` wraps 63 -> 0).
  - Required: pops return 8'h10..8'h19 in order, occupancy tracks 10 -> 0.
- Simultaneous events:
  - Empty plus push 8'h77 with pop -> occupancy 1, head 8'h77.
  - Full plus push 8'hEE with pop -> occupancy 64, 8'hEE is the last byte popped.
  - Both store strobes with `tx_data`=8'h11, `rx_packet_data`=8'h22 -> only 8'h22 stored.
- Occupancy 20:
  - Assert `clear` together with a push -> occupancy 0, next push of 8'h5A reads back as head 8'h5A.
  - Repeat with `flush`: same result.
- Assert `n_rst` low asynchronously mid-stream at occupancy 33 -> `buffer_occupancy` and both data outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/usb_data_buffer.sv
// rtl/usb_data_buffer.sv - shared byte FIFO between bus side and USB packet engines
// First-word-fall-through head, registered occupancy, flush/clear empty the queue.
module usb_data_buffer #(
   parameter int DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    flush,
   input  logic                    clear,
   input  logic                    store_tx_data,
   input  logic [7:0]              tx_data,
   input  logic                    store_rx_packet_data,
   input  logic [7:0]              rx_packet_data,
   input  logic                    get_tx_packet_data,
   input  logic                    get_rx_data,
   output logic [7:0]              tx_packet_data,
   output logic [7:0]              rx_data,
   output logic [$clog2(DEPTH):0]  buffer_occupancy
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]     OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   logic          push_ok;
   logic          pop_ok;
   logic [7:0]    wdata;
   logic [7:0]    head;

   always_comb begin
      push    = store_tx_data | store_rx_packet_data;
      pop     = get_tx_packet_data | get_rx_data;
      empty   = (buffer_occupancy == '0);
      full    = (buffer_occupancy == FULL_CNT);
      // receiver data wins when both sides push in the same cycle
      wdata   = store_rx_packet_data ? rx_packet_data : tx_data;
      pop_ok  = pop & ~empty;
      // a full buffer still accepts a push when a pop frees the slot
      push_ok = push & (~full | pop_ok);
      head    = empty ? 8'h00 : mem[rptr];
   end

   assign tx_packet_data = head;
   assign rx_data        = head;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wptr             <= '0;
         rptr             <= '0;
         buffer_occupancy <= '0;
      end else if (flush || clear) begin
         wptr             <= '0;
         rptr             <= '0;
         buffer_occupancy <= '0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + PTR_ONE;
         end
         if (pop_ok) begin
            rptr <= rptr + PTR_ONE;
         end
         if (push_ok && !pop_ok) begin
            buffer_occupancy <= buffer_occupancy + OCC_ONE;
         end else if (pop_ok && !push_ok) begin
            buffer_occupancy <= buffer_occupancy - OCC_ONE;
         end
      end
   end

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb/tb_usb_data_buffer.sv - randomized self-checking bench for usb_data_buffer
// Reference is a byte queue updated from the push/pop/flush rules.
module tb_usb_data_buffer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       flush = 1'b0;
   logic       clear = 1'b0;
   logic       store_tx_data = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       store_rx_packet_data = 1'b0;
   logic [7:0] rx_packet_data = 8'h00;
   logic       get_tx_packet_data = 1'b0;
   logic       get_rx_data = 1'b0;
   logic [7:0] tx_packet_data;
   logic [7:0] rx_data;
   logic [6:0] buffer_occupancy;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] q[$];

   usb_data_buffer #(.DEPTH(64)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .flush(flush),
      .clear(clear),
      .store_tx_data(store_tx_data),
      .tx_data(tx_data),
      .store_rx_packet_data(store_rx_packet_data),
      .rx_packet_data(rx_packet_data),
      .get_tx_packet_data(get_tx_packet_data),
      .get_rx_data(get_rx_data),
      .tx_packet_data(tx_packet_data),
      .rx_data(rx_data),
      .buffer_occupancy(buffer_occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_occ();
      return 7'(q.size());
   endfunction

   function automatic logic [7:0] exp_head();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   // Applies one cycle of strobes, then advances the reference queue.
   task automatic step(input logic stx, input logic srx, input logic gtx, input logic grx,
                       input logic fl, input logic cl, input logic [7:0] txd, input logic [7:0] rxd);
      bit pop_ok;
      bit push_ok;
      store_tx_data        = stx;
      store_rx_packet_data = srx;
      get_tx_packet_data   = gtx;
      get_rx_data          = grx;
      flush                = fl;
      clear                = cl;
      tx_data              = txd;
      rx_packet_data       = rxd;
      @(posedge clk);
      #1;
      if (fl || cl) begin
         q.delete();
      end else begin
         pop_ok  = (gtx || grx) && q.size() > 0;
         push_ok = (stx || srx) && (q.size() < 64 || pop_ok);
         if (pop_ok) void'(q.pop_front());
         if (push_ok) q.push_back(srx ? rxd : txd);
      end
      store_tx_data        = 1'b0;
      store_rx_packet_data = 1'b0;
      get_tx_packet_data   = 1'b0;
      get_rx_data          = 1'b0;
      flush                = 1'b0;
      clear                = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d, 8'h00);
   endtask

   task automatic pop_byte();
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (buffer_occupancy !== 7'd0) begin
         miscompares++;
         $display("FAIL reset_occ got %0d exp 0", buffer_occupancy);
      end
      vectors++;
      if (tx_packet_data !== 8'h00 || rx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data got tx=%h rx=%h exp 00", tx_packet_data, rx_data);
      end
      n_rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      push_byte(8'hA5);
      push_byte(8'h3C);
      vectors++;
      if (buffer_occupancy !== 7'd2 || tx_packet_data !== 8'hA5) begin
         miscompares++;
         $display("FAIL basic_push got occ=%0d head=%h exp occ=2 head=a5", buffer_occupancy, tx_packet_data);
      end
      pop_byte();
      vectors++;
      if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h3C || rx_data !== 8'h3C) begin
         miscompares++;
         $display("FAIL basic_pop got occ=%0d tx=%h rx=%h exp occ=1 3c", buffer_occupancy, tx_packet_data, rx_data);
      end
      pop_byte();
   endtask

   task automatic test_full();
      for (int i = 0; i < 64; i++) push_byte(8'(i));
      vectors++;
      if (buffer_occupancy !== 7'd64) begin
         miscompares++;
         $display("FAIL full_occ got %0d exp 64", buffer_occupancy);
      end
      push_byte(8'hFF);
      vectors++;
      if (buffer_occupancy !== 7'd64 || tx_packet_data !== 8'h00) begin
         miscompares++;
         $display("FAIL full_overflow got occ=%0d head=%h exp 64 00", buffer_occupancy, tx_packet_data);
      end
      for (int i = 0; i < 64; i++) begin
         vectors++;
         if (tx_packet_data !== 8'(i) || buffer_occupancy !== 7'(64 - i)) begin
            miscompares++;
            $display("FAIL full_drain[%0d] got head=%h occ=%0d exp %h %0d", i, tx_packet_data, buffer_occupancy, 8'(i), 64 - i);
         end
         step(1'b0, 1'b0, i[0], ~i[0], 1'b0, 1'b0, 8'h00, 8'h00);
      end
      vectors++;
      if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin
         miscompares++;
         $display("FAIL full_empty got occ=%0d head=%h exp 0 00", buffer_occupancy, tx_packet_data);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      vectors++;
      if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00 || rx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL underflow got occ=%0d tx=%h rx=%h exp 0 00", buffer_occupancy, tx_packet_data, rx_data);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 60; i++) push_byte(8'($urandom));
      for (int i = 0; i < 60; i++) pop_byte();
      for (int i = 0; i < 10; i++) push_byte(8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (tx_packet_data !== 8'(8'h10 + i) || buffer_occupancy !== 7'(10 - i)) begin
            miscompares++;
            $display("FAIL wrap[%0d] got head=%h occ=%0d exp %h %0d", i, tx_packet_data, buffer_occupancy, 8'(8'h10 + i), 10 - i);
         end
         pop_byte();
      end
      vectors++;
      if (buffer_occupancy !== 7'd0) begin
         miscompares++;
         $display("FAIL wrap_end got occ=%0d exp 0", buffer_occupancy);
      end
   endtask

   task automatic test_simultaneous();
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 8'h00);
      vectors++;
      if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h77) begin
         miscompares++;
         $display("FAIL empty_pushpop got occ=%0d head=%h exp 1 77", buffer_occupancy, tx_packet_data);
      end
      pop_byte();
      for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 8'hED)));
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 8'h00);
      vectors++;
      if (buffer_occupancy !== 7'd64) begin
         miscompares++;
         $display("FAIL full_pushpop got occ=%0d exp 64", buffer_occupancy);
      end
      for (int i = 0; i < 63; i++) begin
         vectors++;
         if (tx_packet_data !== exp_head()) begin
            miscompares++;
            $display("FAIL full_pushpop_drain[%0d] got %h exp %h", i, tx_packet_data, exp_head());
         end
         pop_byte();
      end
      vectors++;
      if (tx_packet_data !== 8'hEE || buffer_occupancy !== 7'd1) begin
         miscompares++;
         $display("FAIL full_pushpop_last got head=%h occ=%0d exp ee 1", tx_packet_data, buffer_occupancy);
      end
      pop_byte();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22);
      vectors++;
      if (buffer_occupancy !== 7'd1 || rx_data !== 8'h22) begin
         miscompares++;
         $display("FAIL dual_store got occ=%0d head=%h exp 1 22", buffer_occupancy, rx_data);
      end
      pop_byte();
   endtask

   task automatic test_clear_flush();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 20; i++) push_byte(8'($urandom));
         step(1'b1, 1'b0, 1'b0, 1'b0, k == 1, k == 0, 8'h99, 8'h00);
         vectors++;
         if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin
            miscompares++;
            $display("FAIL empty_req[%0d] got occ=%0d head=%h exp 0 00", k, buffer_occupancy, tx_packet_data);
         end
         push_byte(8'h5A);
         vectors++;
         if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL empty_req_push[%0d] got occ=%0d head=%h exp 1 5a", k, buffer_occupancy, tx_packet_data);
         end
         pop_byte();
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 33; i++) push_byte(8'($urandom_range(1, 255)));
      vectors++;
      if (buffer_occupancy !== 7'd33 || tx_packet_data !== exp_head()) begin
         miscompares++;
         $display("FAIL prereset got occ=%0d head=%h exp 33 %h", buffer_occupancy, tx_packet_data, exp_head());
      end
      #1 n_rst = 1'b0;
      #1;
      vectors++;
      if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00 || rx_data !== 8'h00) begin
         miscompares++;
         $display("FAIL async_reset got occ=%0d tx=%h rx=%h exp 0 00", buffer_occupancy, tx_packet_data, rx_data);
      end
      q.delete();
      #1 n_rst = 1'b1;
   endtask

   task automatic test_random();
      logic stx, srx, gtx, grx, fl, cl;
      int bias;
      for (int n = 0; n < 3000; n++) begin
         // drift between fill-heavy and drain-heavy phases to reach both ends
         bias = ((n / 300) % 2 == 0) ? 75 : 25;
         stx  = ($urandom_range(0, 99) < bias);
         srx  = ($urandom_range(0, 99) < 15);
         gtx  = ($urandom_range(0, 99) < (100 - bias));
         grx  = ($urandom_range(0, 99) < 10);
         fl   = ($urandom_range(0, 499) == 0);
         cl   = ($urandom_range(0, 499) == 0);
         step(stx, srx, gtx, grx, fl, cl, 8'($urandom), 8'($urandom));
         vectors++;
         if (buffer_occupancy !== exp_occ() || tx_packet_data !== exp_head() || rx_data !== exp_head()) begin
            miscompares++;
            $display("FAIL random[%0d] got occ=%0d tx=%h rx=%h exp occ=%0d head=%h",
                     n, buffer_occupancy, tx_packet_data, rx_data, exp_occ(), exp_head());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_simultaneous();
      test_clear_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
